wave_xfade_mux: RTL and testbench

Parametrised N-channel waveform selector with a click-free linear crossfade. It sits between the DDS waveform generators (sine/square/triangle/saw amplitude outputs) and the output DAC/PWM stage. It replaces a hard combinational select with a registered, sample-strobed output. When the selection changes, the output blends from the old channel to the new one over 2^XF_BITS samples, so the audio output never steps abruptly.

---
 rtl/wave_xfade_mux.sv | 147 ++++++++++++++
 tb/tb_wave_xfade_mux.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_xfade_mux.sv
// -----------------------------------------------------------------------------
// wave_xfade_mux
// N-channel waveform selector with a click-free linear crossfade. Sits between
// the DDS generators and the DAC/PWM stage. All state advances only on
// sample_en strobes. A change of sel blends from the old channel to the new
// one over L = 2^XF_BITS samples. XF_BITS = 0 gives an immediate, registered
// switch.
//
// Parameters
//   M        sample width (unsigned samples)
//   N        number of input channels (N >= 2)
//   XF_BITS  crossfade length exponent
//   SW       select width, derived from N (leave at default)
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   sample_en  one-cycle strobe marking a new sample period
//   in_bus     packed channel samples, channel c = in_bus[c*M +: M]
//   sel        requested channel, sampled on strobes while not fading
//   out        registered mixed sample
//   out_valid  one-cycle pulse the cycle after each strobe
//   busy       high while a crossfade is in progress
// -----------------------------------------------------------------------------
module wave_xfade_mux #(
  parameter int M       = 12,
  parameter int N       = 4,
  parameter int XF_BITS = 2,
  parameter int SW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sample_en,
  input  logic [N*M-1:0] in_bus,
  input  logic [SW-1:0]  sel,
  output logic [M-1:0]   out,
  output logic           out_valid,
  output logic           busy
);

  logic [SW-1:0] cur_sel;
  logic          sel_ok;
  logic [M-1:0]  cur_sample;

  // sel can only be out of range when N is not a power of two.
  assign sel_ok     = (int'(sel) < N);
  assign cur_sample = in_bus[int'(cur_sel)*M +: M];

  if (XF_BITS == 0) begin : g_direct

    logic [M-1:0] sel_sample;

    // Only consumed when sel_ok, so an out-of-range sel never reaches out.
    assign sel_sample = in_bus[int'(sel)*M +: M];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values and simulation matches hardware.
    always_ff @(posedge clk) begin
      if (rst) begin
        out       <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        cur_sel   <= '0;
      end else begin
        out_valid <= sample_en;
        busy      <= 1'b0;
        if (sample_en) begin
          if (sel_ok) begin
            out     <= sel_sample;
            cur_sel <= sel;
          end else begin
            out <= cur_sample;
          end
        end
      end
    end

  end else begin : g_fade

    // a*(L-k) + b*k peaks below 2^(M+XF_BITS); one spare bit keeps the
    // subtraction L-k and the sum comfortably inside the datapath.
    localparam int                LW     = M + XF_BITS + 1;
    localparam logic [LW-1:0]     L_FULL = LW'(2 ** XF_BITS);
    localparam logic [XF_BITS-1:0] K_LAST = '1;

    typedef enum logic {IDLE, FADE} state_t;

    state_t             state;
    logic [SW-1:0]      nxt_sel;
    logic [XF_BITS-1:0] k;
    logic [M-1:0]       nxt_sample;
    logic [LW-1:0]      mix_sum;
    logic [M-1:0]       mix_out;

    assign nxt_sample = in_bus[int'(nxt_sel)*M +: M];

    // NOTE: every output of this block is assigned on every pass, so no
    // latch can be inferred.
    always_comb begin
      mix_sum = LW'(cur_sample) * (L_FULL - LW'(k)) + LW'(nxt_sample) * LW'(k);
      // Shift truncates toward zero; no rounding on purpose.
      mix_out = M'(mix_sum >> XF_BITS);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out       <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        cur_sel   <= '0;
        nxt_sel   <= '0;
        k         <= '0;
        state     <= IDLE;
      end else begin
        out_valid <= sample_en;
        if (sample_en) begin
          case (state)
            IDLE: begin
              out <= cur_sample;
              if (sel_ok && (sel != cur_sel)) begin
                nxt_sel <= sel;
                k       <= XF_BITS'(1);
                state   <= FADE;
                busy    <= 1'b1;
              end
            end
            FADE: begin
              // sel is deliberately ignored here: no retargeting mid-fade.
              out <= mix_out;
              if (k == K_LAST) begin
                cur_sel <= nxt_sel;
                k       <= '0;
                state   <= IDLE;
                busy    <= 1'b0;
              end else begin
                k <= k + XF_BITS'(1);
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end

  end

endmodule

// File: tb/tb_wave_xfade_mux.sv
// -----------------------------------------------------------------------------
// tb_wave_xfade_mux
// Drives two instances: the default crossfading build (M=12, N=4, XF_BITS=2)
// and an immediate-switch build (M=12, N=3, XF_BITS=0). Expected values come
// from a reference model: a fade is a queue of pending blend weights, and each
// mixed sample is computed with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_wave_xfade_mux;

  localparam int M  = 12;
  localparam int N  = 4;
  localparam int XF = 2;
  localparam int L  = 1 << XF;
  localparam int N0 = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            sample_en = 1'b0;
  logic [N*M-1:0]  in_bus = '0;
  logic [1:0]      sel = '0;
  logic [M-1:0]    out;
  logic            out_valid;
  logic            busy;
  logic [N0*M-1:0] in_bus0 = '0;
  logic [1:0]      sel0 = '0;
  logic [M-1:0]    out0;
  logic            out_valid0;
  logic            busy0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_cur  = 0;
  int m_tgt  = 0;
  int m_cur0 = 0;
  int fade_q[$];
  int exp_out  = 0;
  int exp_busy = 0;
  int exp_out0 = 0;

  always #5 clk = ~clk;

  wave_xfade_mux #(.M(M), .N(N), .XF_BITS(XF)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .in_bus(in_bus), .sel(sel),
    .out(out), .out_valid(out_valid), .busy(busy)
  );

  wave_xfade_mux #(.M(M), .N(N0), .XF_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .sample_en(sample_en), .in_bus(in_bus0), .sel(sel0),
    .out(out0), .out_valid(out_valid0), .busy(busy0)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ch4(input logic [N*M-1:0] b, input int c);
    return int'(b[c*M +: M]);
  endfunction

  function automatic int ch3(input logic [N0*M-1:0] b, input int c);
    return int'(b[c*M +: M]);
  endfunction

  function automatic logic [N*M-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [N*M-1:0] b;
    b = {M'(a3), M'(a2), M'(a1), M'(a0)};
    return b;
  endfunction

  function automatic logic [N0*M-1:0] pack3(input int a0, input int a1, input int a2);
    logic [N0*M-1:0] b;
    b = {M'(a2), M'(a1), M'(a0)};
    return b;
  endfunction

  function automatic logic [N*M-1:0] rand4();
    logic [N*M-1:0] b;
    for (int c = 0; c < N; c++) b[c*M +: M] = M'($urandom);
    return b;
  endfunction

  function automatic logic [N0*M-1:0] rand3();
    logic [N0*M-1:0] b;
    for (int c = 0; c < N0; c++) b[c*M +: M] = M'($urandom);
    return b;
  endfunction

  // One sample period of the reference behaviour, evaluated on strobe inputs.
  task automatic model_strobe();
    int s, s0, w, a, b;
    s  = int'(sel);
    s0 = int'(sel0);
    if (fade_q.size() == 0) begin
      exp_out = ch4(in_bus, m_cur);
      if (s != m_cur && s < N) begin
        m_tgt = s;
        for (int i = 1; i < L; i++) fade_q.push_back(i);
      end
    end else begin
      w = fade_q.pop_front();
      a = ch4(in_bus, m_cur);
      b = ch4(in_bus, m_tgt);
      exp_out = (a * (L - w) + b * w) / L;
      if (fade_q.size() == 0) m_cur = m_tgt;
    end
    exp_busy = (fade_q.size() != 0) ? 1 : 0;
    if (s0 < N0) begin
      exp_out0 = ch3(in_bus0, s0);
      m_cur0   = s0;
    end else begin
      exp_out0 = ch3(in_bus0, m_cur0);
    end
  endtask

  task automatic check_all(input int valid_exp);
    check("out", int'(out), exp_out);
    check("out_valid", int'(out_valid), valid_exp);
    check("busy", int'(busy), exp_busy);
    check("out0", int'(out0), exp_out0);
    check("out_valid0", int'(out_valid0), valid_exp);
    check("busy0", int'(busy0), 0);
  endtask

  task automatic do_strobe(input int s, input int s0,
                           input logic [N*M-1:0] ib, input logic [N0*M-1:0] ib0);
    @(negedge clk);
    sel       = 2'(s);
    sel0      = 2'(s0);
    in_bus    = ib;
    in_bus0   = ib0;
    sample_en = 1'b1;
    model_strobe();
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    check_all(1);
  endtask

  // Gap cycles between strobes; inputs may wander, outputs must hold.
  task automatic idle_cycles(input int n, input bit wiggle);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wiggle) begin
        in_bus  = rand4();
        in_bus0 = rand3();
        sel     = 2'($urandom_range(0, 3));
        sel0    = 2'($urandom_range(0, 3));
      end
      @(posedge clk);
      #1;
      check_all(0);
    end
  endtask

  // Reset held with sample_en high: reset must win.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst       = 1'b1;
    sample_en = 1'b1;
    m_cur = 0; m_tgt = 0; m_cur0 = 0;
    fade_q.delete();
    exp_out = 0; exp_busy = 0; exp_out0 = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_all(0);
    end
    rst       = 1'b0;
    sample_en = 1'b0;
  endtask

  logic [N*M-1:0]  xb;
  logic [N0*M-1:0] xb0;
  int rs, rs0;

  initial begin
    do_reset(2);

    // First strobe after reset.
    do_strobe(0, 0, pack4('h123, 'h456, 'h789, 'hABC), pack3('h123, 'h321, 'h555));
    check("first_out", int'(out), 'h123);

    // Crossfade 0 -> 1, strobe every 3 clocks; sel moves to 3 mid-fade.
    xb  = pack4('h000, 'hFFF, 'h111, 'h800);
    xb0 = pack3('h0A0, 'h0B0, 'h0C0);
    do_strobe(1, 2, xb, xb0);
    check("xf_old", int'(out), 'h000);
    check("sw0_imm", int'(out0), 'h0C0);
    idle_cycles(2, 0);
    do_strobe(1, 3, xb, xb0);
    check("xf_k1", int'(out), 'h3FF);
    check("sw0_hold", int'(out0), 'h0C0);
    idle_cycles(2, 0);
    do_strobe(3, 3, xb, xb0);
    check("xf_k2", int'(out), 'h7FF);
    idle_cycles(2, 0);
    do_strobe(3, 3, xb, xb0);
    check("xf_k3", int'(out), 'hBFF);
    check("xf_busy_fall", int'(busy), 0);
    idle_cycles(2, 0);
    do_strobe(3, 1, xb, xb0);
    check("xf_new", int'(out), 'hFFF);
    check("xf_retarget_busy", int'(busy), 1);
    for (int i = 0; i < L; i++) begin
      do_strobe(3, 1, xb, xb0);
      idle_cycles(1, 0);
    end
    check("xf_to3", int'(out), 'h800);

    // Reset mid-fade at k = 2.
    do_strobe(0, 0, xb, xb0);
    do_strobe(0, 0, xb, xb0);
    do_reset(1);
    xb = pack4('h5A5, 'h111, 'h222, 'h333);
    do_strobe(0, 0, xb, xb0);
    check("post_rst_in0", int'(out), 'h5A5);
    check("post_rst_busy", int'(busy), 0);

    // Randomised run: back-to-back and spaced strobes, inputs moving in gaps.
    rs = 0; rs0 = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rs = int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) rs0 = int'($urandom_range(0, 3));
      do_strobe(rs, rs0, rand4(), rand3());
      idle_cycles(int'($urandom_range(0, 2)), 1);
      if (i == 200) do_reset(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
